serial_word_tx: RTL
===================

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 Parameter GAP, default 0, idle cycles inserted between consecutive words (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge, so ser_out is stable at the downstream falling-edge sample point.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  serial bit stream, LSB first, feeds the downstream shift-register serial input.
REQ-009 ser_en  output  1  ser_out carries a valid data bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse coincident with the last (MSB) bit of each word.
REQ-011 busy  output  1  high while a word is held or being shifted.

Function
REQ-012 Handshake: a word transfers at a rising edge where in_valid=1 and in_ready=1; in_data is captured into a one-entry holding buffer.
REQ-013 in_ready = holding buffer empty and rst high; no combinational path from in_valid to in_ready.
REQ-014 FSM states IDLE, SHIFT, GAP; IDLE->SHIFT when buffer full; SHIFT->GAP after bit WIDTH-1 if GAP>0; SHIFT->SHIFT (reload) after last bit if GAP=0 and buffer full; SHIFT->IDLE after last bit if GAP=0 and buffer empty; GAP->SHIFT/IDLE after GAP cycles depending on buffer.
REQ-015 Latency: word accepted at edge t drives bit 0 on ser_out from edge t+1 when FSM is IDLE; bit i appears in cycle t+1+i.
REQ-016 Entering SHIFT moves the buffer into the shifter and empties the buffer at the same edge; a new word may be accepted at that same edge only if in_ready was already high before it.
REQ-017 With GAP=0 and buffer refilled in time, words are emitted back-to-back with ser_en continuously high.
REQ-018 In IDLE and GAP: ser_out=0, ser_en=0, word_done=0.
REQ-019 Bit counter is ceil(log2(WIDTH)) bits and never exceeds WIDTH-1; gap counter 4 bits.
REQ-020 busy = (FSM != IDLE) or buffer full.

Reset
REQ-021 While rst=0: FSM=IDLE, buffer empty, shifter and counters zero, ser_out=0, ser_en=0, word_done=0, busy=0, in_ready=0.
REQ-022 Reset asserted mid-word aborts immediately; the partial word and any buffered word are discarded, no word_done is produced.
REQ-023 First accept is possible at the first rising edge after rst returns high.

Structure
REQ-024 Shared package serial_word_tx_pkg holds the FSM state enum and constants DEFAULT_WIDTH=8, DEFAULT_GAP=0, MAX_GAP=15.
REQ-025 One sub-module ser_hold_buf implements the one-entry holding buffer (load, drain, full flag); FSM, shifter and counters stay in the top module.

Verification
REQ-026 WIDTH=8, GAP=0, send 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 in cycles 1..8 after accept, word_done in cycle 8 only; downstream 8-bit shift register parOut=8'hA5 after its 8th sampling edge.
REQ-027 GAP=0, in_valid held with 8'h3C then 8'hC3 -> 16 consecutive ser_en cycles, stream 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1, two word_done pulses 8 cycles apart.
REQ-028 GAP=2, two words 8'hFF,8'h01 -> 8 bits, 2 cycles ser_en=0/ser_out=0, then 1,0,0,0,0,0,0,0.
REQ-029 Backpressure: three words offered continuously -> in_ready low whenever buffer full, no word lost or duplicated, output order matches input order.
REQ-030 rst pulled low during bit 4 of 8'h5A with a buffered word -> ser_out, ser_en, busy, in_ready 0 asynchronously; after release, IDLE and next accepted word 8'h81 transmits cleanly.

Source files
------------

// File: rtl/serial_word_tx_pkg.sv
// Shared types and constants for the serial word transmitter.
package serial_word_tx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_GAP   = 0;
  localparam int unsigned MAX_GAP       = 15;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } tx_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer between the parallel handshake and the shifter.
module ser_hold_buf
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_drain,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Load only happens while empty and drain only while full, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, optional idle gap between words.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);
  localparam logic [3:0]       GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [CntW-1:0]  r_bit;
  logic [3:0]       r_gap;

  logic             w_load;
  logic             w_drain;
  logic             w_full;
  logic [WIDTH-1:0] w_buf_data;
  logic             w_shifting;
  logic             w_last_bit;

  // in_ready depends only on buffer state and reset, never on in_valid.
  assign in_ready = ~w_full & rst;
  assign w_load   = in_valid & in_ready;

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (in_data),
    .i_drain (w_drain),
    .o_full  (w_full),
    .o_data  (w_buf_data)
  );

  assign w_shifting = (r_state == StShift);
  assign w_last_bit = w_shifting && (r_bit == LastBit);

  // Next-state decode; w_drain marks the edge that moves the buffer into the shifter.
  always_comb begin
    w_state_next = r_state;
    w_drain      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_full) begin
          w_state_next = StShift;
          w_drain      = 1'b1;
        end
      end
      StShift: begin
        if (r_bit == LastBit) begin
          if (GAP > 0) begin
            w_state_next = StGap;
          end else if (w_full) begin
            w_state_next = StShift;
            w_drain      = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          if (w_full) begin
            w_state_next = StShift;
            w_drain      = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shifter and bit counter; the counter wraps to zero after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_bit   <= '0;
    end else if (w_drain) begin
      r_shift <= w_buf_data;
      r_bit   <= '0;
    end else if (w_shifting) begin
      r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      r_bit   <= (r_bit == LastBit) ? '0 : r_bit + CntW'(1);
    end
  end

  // Gap counter runs only while in the gap state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap <= '0;
    end else if (r_state == StGap) begin
      r_gap <= r_gap + 4'd1;
    end else begin
      r_gap <= '0;
    end
  end

  assign ser_en    = w_shifting;
  assign ser_out   = w_shifting & r_shift[0];
  assign word_done = w_last_bit;
  assign busy      = (r_state != StIdle) | w_full;

endmodule
